// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the pattern serializer and its downstream detector bench.
// Holds the FSM state encoding, default geometry and a counter-width helper.
package pattern_serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DIV   = 1;

   // Counters sized to hold 0..n-1; a count of one still needs a single bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pattern_serializer_if.sv
// Load handshake plus serial output bundle of the pattern serializer.
// The master is the word producer; the slave is the serializer itself.
interface pattern_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] load_data;
   logic             load_valid;
   logic             load_ready;
   logic             nwbit;
   logic             bit_strobe;
   logic             busy;

   modport master (
      output load_data, load_valid,
      input  load_ready, nwbit, bit_strobe, busy
   );

   modport slave (
      input  load_data, load_valid,
      output load_ready, nwbit, bit_strobe, busy
   );
endinterface

// File: rtl/pattern_serializer_tick_gen.sv
// Bit hold counter: counts 0..DIV-1 and flags the final hold cycle of each bit.
// clear forces the count back to the first hold cycle.
module ser_tick_gen
   import pattern_serializer_pkg::*;
#(
   parameter int DIV = DEFAULT_DIV
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic clear,
   output logic tick
);
   localparam int            CW   = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] hold_cnt_q, hold_cnt_d;

   assign tick = (hold_cnt_q == LAST);

   always_comb begin
      hold_cnt_d = hold_cnt_q + CW'(1);
      if (clear || tick) begin
         hold_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
endmodule

// File: rtl/pattern_serializer.sv
// MSB-first word serializer feeding a pattern detector; idles with nwbit high.
// Each bit is held DIV cycles, and a new word may be taken on the last hold cycle of bit 0.
module pattern_serializer
   import pattern_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DIV   = DEFAULT_DIV
) (
   input  logic CLK,
   input  logic RSTn,
   pattern_serializer_if.slave bus
);
   localparam int            BW      = cnt_width(WIDTH);
   localparam logic [BW-1:0] TOP_BIT = BW'(WIDTH - 1);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             strobe_q, strobe_d;
   logic             tick, last_cycle, load_ready, xfer, hold_clear;

   // The hold count restarts whenever a fresh word is captured.
   assign last_cycle = (state_q == ST_SHIFT) && tick && (bit_cnt_q == '0);
   assign load_ready = (state_q == ST_IDLE) || last_cycle;
   assign xfer       = bus.load_valid && load_ready;
   assign hold_clear = (state_q == ST_IDLE) || xfer;

   ser_tick_gen #(.DIV(DIV)) u_tick (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .clear (hold_clear),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      strobe_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               state_d   = ST_SHIFT;
               shift_d   = bus.load_data;
               bit_cnt_d = TOP_BIT;
               strobe_d  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (xfer) begin
               shift_d   = bus.load_data;
               bit_cnt_d = TOP_BIT;
               strobe_d  = 1'b1;
            end else if (last_cycle) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               shift_d   = {shift_q[WIDTH-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q - BW'(1);
               strobe_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         strobe_q  <= strobe_d;
      end
   end

   assign bus.nwbit      = (state_q == ST_SHIFT) ? shift_q[WIDTH-1] : 1'b1;
   assign bus.busy       = (state_q == ST_SHIFT);
   assign bus.bit_strobe = strobe_q;
   assign bus.load_ready = load_ready;
endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: three instances cover DIV=1, DIV=3 and WIDTH=2,
// with a small 0111 detector model fed from nwbit on each bit_strobe.
module tb_pattern_serializer;
   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   pattern_serializer_if #(.WIDTH(8)) if0 ();
   pattern_serializer_if #(.WIDTH(8)) if1 ();
   pattern_serializer_if #(.WIDTH(2)) if2 ();

   pattern_serializer #(.WIDTH(8), .DIV(1)) dut0 (.CLK(clk), .RSTn(rst_n), .bus(if0.slave));
   pattern_serializer #(.WIDTH(8), .DIV(3)) dut1 (.CLK(clk), .RSTn(rst_n), .bus(if1.slave));
   pattern_serializer #(.WIDTH(2), .DIV(1)) dut2 (.CLK(clk), .RSTn(rst_n), .bus(if2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int idx, input logic [7:0] d, input logic v);
      case (idx)
         0: begin if0.load_data = d;      if0.load_valid = v; end
         1: begin if1.load_data = d;      if1.load_valid = v; end
         default: begin if2.load_data = d[1:0]; if2.load_valid = v; end
      endcase
   endtask

   task automatic sample(input int idx, output logic nw, output logic st, output logic bz, output logic rd);
      case (idx)
         0: begin nw = if0.nwbit; st = if0.bit_strobe; bz = if0.busy; rd = if0.load_ready; end
         1: begin nw = if1.nwbit; st = if1.bit_strobe; bz = if1.busy; rd = if1.load_ready; end
         default: begin nw = if2.nwbit; st = if2.bit_strobe; bz = if2.busy; rd = if2.load_ready; end
      endcase
   endtask

   task automatic checkIdle(input int idx, input string tag);
      logic nw, st, bz, rd;
      sample(idx, nw, st, bz, rd);
      checkOutput({tag, " idle nwbit"}, nw, 1'b1);
      checkOutput({tag, " idle strobe"}, st, 1'b0);
      checkOutput({tag, " idle busy"}, bz, 1'b0);
      checkOutput({tag, " idle ready"}, rd, 1'b1);
   endtask

   task automatic applyStimulus(input int idx, input logic [7:0] d);
      drive(idx, d, 1'b1);
      @(posedge clk); #1;
      drive(idx, d, 1'b0);
   endtask

   // mode 0: single word; 1: next_word offered on the final cycle; 2: valid held with junk before that
   task automatic checkBits(input int idx, input string tag, input logic [15:0] stream,
                            input int nbits, input int div, input int word_len, input int mode,
                            input logic [7:0] next_word, output int match_at,
                            output int strobes, output int busy_cycles);
      logic nw, st, bz, rd;
      logic [3:0] hist;
      int bi;
      hist = 4'hF;
      match_at = 0;
      strobes = 0;
      busy_cycles = 0;
      for (int i = 0; i < nbits * div; i++) begin
         bi = i / div;
         sample(idx, nw, st, bz, rd);
         checkOutput({tag, " nwbit"}, nw, stream[nbits-1-bi]);
         checkOutput({tag, " busy"}, bz, 1'b1);
         checkOutput({tag, " strobe"}, st, (i % div) == 0);
         checkOutput({tag, " ready"}, rd, ((bi % word_len) == word_len - 1) && ((i % div) == div - 1));
         if (st) begin
            strobes++;
            hist = {hist[2:0], nw};
            if (hist == 4'b0111 && match_at == 0) match_at = bi + 1;
         end
         if (bz) busy_cycles++;
         if (mode != 0 && i == word_len * div - 1) drive(idx, next_word, 1'b1);
         else if (mode == 2 && i < word_len * div - 1) drive(idx, 8'h5A ^ 8'(i * 37), 1'b1);
         else drive(idx, 8'(i * 19), 1'b0);
         @(posedge clk); #1;
      end
      drive(idx, 8'h00, 1'b0);
      checkIdle(idx, tag);
   endtask

   initial begin
      int m, s, b;
      logic nw, st, bz, rd;
      rst_n = 1'b1;
      drive(0, 8'h00, 1'b0);
      drive(1, 8'h00, 1'b0);
      drive(2, 8'h00, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      checkIdle(0, "reset0");
      checkIdle(1, "reset1");
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      checkIdle(2, "reset2");

      drive(0, 8'h00, 1'b0);
      @(posedge clk); #1;
      drive(0, 8'hAA, 1'b0);
      @(posedge clk); #1;
      checkIdle(0, "idle data change");

      applyStimulus(0, 8'h70);
      checkBits(0, "w70", 16'h0070, 8, 1, 8, 0, 8'h00, m, s, b);
      checkOutput("w70 match bit", m, 4);
      checkOutput("w70 busy cycles", b, 8);

      applyStimulus(1, 8'hA5);
      checkBits(1, "wA5", 16'h00A5, 8, 3, 8, 0, 8'h00, m, s, b);
      checkOutput("wA5 strobes", s, 8);
      checkOutput("wA5 busy cycles", b, 24);

      applyStimulus(0, 8'h00);
      checkBits(0, "b2b", 16'h00E0, 16, 1, 8, 1, 8'hE0, m, s, b);
      checkOutput("b2b match bit", m, 11);
      checkOutput("b2b busy cycles", b, 16);

      applyStimulus(0, 8'hC3);
      checkBits(0, "hold", 16'hC381, 16, 1, 8, 2, 8'h81, m, s, b);
      checkOutput("hold busy cycles", b, 16);

      applyStimulus(0, 8'h0F);
      for (int i = 0; i < 3; i++) begin
         sample(0, nw, st, bz, rd);
         checkOutput("abort pre nwbit", nw, 1'b0);
         if (i < 2) begin
            @(posedge clk); #1;
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checkIdle(0, "abort");
      #1 rst_n = 1'b1;
      applyStimulus(0, 8'h3C);
      checkBits(0, "w3C", 16'h003C, 8, 1, 8, 0, 8'h00, m, s, b);
      checkOutput("w3C busy cycles", b, 8);

      applyStimulus(2, 8'h01);
      checkBits(2, "w2", 16'h0001, 2, 1, 2, 0, 8'h00, m, s, b);
      checkOutput("w2 busy cycles", b, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end
endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 Parameter WIDTH, default 8, bits per loaded word (legal range 2..32).
REQ-002 Parameter DIV, default 1, CLK cycles each bit is held on the output (legal range 1..65535).
REQ-003 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port RSTn  input  1  reset; asynchronous, active-low.
REQ-005 Port load_data  input  WIDTH  word to serialize, MSB transmitted first.
REQ-006 Port load_valid  input  1  producer offers load_data this cycle.
REQ-007 Port load_ready  output  1  block accepts load_data this cycle.
REQ-008 Port nwbit  output  1  serial bit to the downstream pattern detector.
REQ-009 Port bit_strobe  output  1  one-cycle pulse marking the first cycle a new bit is presented on nwbit.
REQ-010 Port busy  output  1  high while a word is being shifted out.

Function
REQ-011 Transfer occurs on a rising edge where load_valid and load_ready are both high; no other condition captures load_data.
REQ-012 FSM states: IDLE and SHIFT only; IDLE -> SHIFT on transfer; SHIFT -> IDLE after final hold cycle of bit 0 with no transfer; SHIFT -> SHIFT on back-to-back transfer.
REQ-013 In IDLE: nwbit = 1, bit_strobe = 0, busy = 0, load_ready = 1.
REQ-014 Cycle after transfer: nwbit = load_data[WIDTH-1], bit_strobe = 1, busy = 1, hold counter = 0, bit counter = WIDTH-1.
REQ-015 Each bit is held exactly DIV cycles; at end of hold, shift register shifts left by one, next bit appears on nwbit, bit_strobe pulses for one cycle.
REQ-016 Hold counter counts 0..DIV-1 and wraps to 0; with DIV = 1 a new bit appears every cycle and bit_strobe stays high throughout SHIFT.
REQ-017 In SHIFT, load_ready = 1 only during the final hold cycle of the last bit (bit 0); all other SHIFT cycles load_ready = 0 and load_valid is ignored.
REQ-018 Back-to-back transfer on that final cycle: next word's MSB appears on the following cycle with bit_strobe = 1, no idle gap, busy stays 1.
REQ-019 A word occupies exactly WIDTH*DIV cycles of busy = 1; with no back-to-back transfer, busy falls and nwbit returns to 1 on the cycle after the final hold cycle.
REQ-020 Idle level of nwbit is 1 so the downstream detector is held in its start state between words.
REQ-021 Changes to load_data while not transferring have no effect on nwbit.

Reset
REQ-022 RSTn low forces, asynchronously: state = IDLE, nwbit = 1, bit_strobe = 0, busy = 0, load_ready = 1, shift register = 0, both counters = 0.
REQ-023 Reset asserted mid-word abandons the word; after release the block is in IDLE and the remaining bits are never emitted.
REQ-024 First transfer is possible on the first rising edge after RSTn deasserts.

Structure
REQ-025 State encoding (IDLE, SHIFT) and default WIDTH/DIV constants belong in a shared package used by the serializer and the detector bench.
REQ-026 The hold counter with its wrap pulse is one sub-module, ser_tick_gen (parameter DIV, inputs CLK, RSTn, clear; output tick).
REQ-027 Downstream detector advances only on bit_strobe when DIV > 1; with DIV = 1 nwbit connects directly.

Verification
REQ-028 WIDTH=8, DIV=1, load 8'b0111_0000 -> nwbit sequence 0,1,1,1,0,0,0,0 on 8 consecutive cycles, busy high 8 cycles, detector match on 4th bit.
REQ-029 WIDTH=8, DIV=3, load 8'hA5 -> each bit held 3 cycles, bit_strobe every 3rd cycle (8 pulses), busy high 24 cycles.
REQ-030 Back-to-back: load 8'h00 then 8'hE0 on final cycle -> 16 contiguous bits, no nwbit=1 gap, busy never drops, detector match on bit 11 (stream ...0,1,1,1).
REQ-031 load_valid held high with changing load_data during SHIFT -> only the first word emitted; second accepted only on final bit cycle.
REQ-032 RSTn pulsed low after 3 bits of 8'h0F -> nwbit = 1, busy = 0 immediately; next load 8'h3C emits all 8 bits from MSB.
REQ-033 DIV=1, WIDTH=2, load 2'b01 -> nwbit 0,1 then idle 1; load_ready high on cycle 2 of SHIFT.
